control_sequencer: RTL and testbench

//  SUP-1 control unit: the initiator of every bus transfer the ram block and
//  the other bus agents respond to. Runs the microstep counter, decodes the
//  IR opcode and flags, and drives one control word per clock
//  (mi/ro/ri plus PC, IR, A, B, ALU and OUT strobes). Sits beside the IR;
//  its outputs fan out to every bus agent.

---
 rtl/sup1_pkg.sv | 56 +++++
 rtl/control_rom.sv | 86 ++++++++
 rtl/control_sequencer.sv | 96 +++++++++
 tb/tb_control_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sup1_pkg.sv
// Shared SUP-1 definitions: opcodes, control-word layout and microstep limits.
// Used by the sequencer, its decode ROM, the IR and the assembler-side bench.
package sup1_pkg;

    localparam int OPCODE_W = 4;
    localparam int STEP_W   = 3;
    localparam int MAX_STEP = 4;
    localparam int CW_W     = 15;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit indices of the packed control word, MSB first.
    localparam int CW_CO = 14;
    localparam int CW_CE = 13;
    localparam int CW_J  = 12;
    localparam int CW_MI = 11;
    localparam int CW_RO = 10;
    localparam int CW_RI = 9;
    localparam int CW_II = 8;
    localparam int CW_IO = 7;
    localparam int CW_AI = 6;
    localparam int CW_AO = 5;
    localparam int CW_BI = 4;
    localparam int CW_EO = 3;
    localparam int CW_SU = 2;
    localparam int CW_FI = 1;
    localparam int CW_OI = 0;

    typedef struct packed {
        logic co;
        logic ce;
        logic j;
        logic mi;
        logic ro;
        logic ri;
        logic ii;
        logic io;
        logic ai;
        logic ao;
        logic bi;
        logic eo;
        logic su;
        logic fi;
        logic oi;
    } ctrl_t;

endpackage

// File: rtl/control_rom.sv
// Combinational microcode decode: (step, opcode, flags) -> control word,
// plus the last-step marker and the halt request for the sequencer.
module control_rom
    import sup1_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [STEP_W-1:0]   step,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output ctrl_t               cw,
    output logic                last_step,
    output logic                halt_req
);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        halt_req  = 1'b0;
        if (step == 3'd0) begin
            cw.co = 1'b1;
            cw.mi = 1'b1;
        end else if (step == 3'd1) begin
            cw.ro = 1'b1;
            cw.ii = 1'b1;
            cw.ce = 1'b1;
        end else begin
            // Execute steps end the instruction unless a multi-step op clears this.
            last_step = 1'b1;
            case (opcode)
                OP_LDA, OP_STA: begin
                    if (step == 3'd2) begin
                        cw.io     = 1'b1;
                        cw.mi     = 1'b1;
                        last_step = 1'b0;
                    end else if (step == 3'd3) begin
                        cw.ro = (opcode == OP_LDA);
                        cw.ai = (opcode == OP_LDA);
                        cw.ao = (opcode == OP_STA);
                        cw.ri = (opcode == OP_STA);
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (step == 3'd2) begin
                        cw.io     = 1'b1;
                        cw.mi     = 1'b1;
                        last_step = 1'b0;
                    end else if (step == 3'd3) begin
                        cw.ro     = 1'b1;
                        cw.bi     = 1'b1;
                        last_step = 1'b0;
                    end else if (step == 3'd4) begin
                        cw.eo = 1'b1;
                        cw.ai = 1'b1;
                        cw.fi = 1'b1;
                        cw.su = (opcode == OP_SUB);
                    end
                end
                OP_LDI: begin
                    cw.io = (step == 3'd2);
                    cw.ai = (step == 3'd2);
                end
                OP_JMP: begin
                    cw.io = (step == 3'd2);
                    cw.j  = (step == 3'd2);
                end
                OP_JC: begin
                    cw.io = (step == 3'd2) && flag_c;
                    cw.j  = (step == 3'd2) && flag_c;
                end
                OP_JZ: begin
                    cw.io = (step == 3'd2) && flag_z;
                    cw.j  = (step == 3'd2) && flag_z;
                end
                OP_OUT: begin
                    cw.ao = (step == 3'd2);
                    cw.oi = (step == 3'd2);
                end
                OP_HLT: halt_req = (step == 3'd2);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SUP-1 control unit: microstep counter, halt latch and reset gating around
// the decode ROM; drives one control word per clock to every bus agent.
module control_sequencer
    import sup1_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int MAX_STEP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic                co,
    output logic                ce,
    output logic                j,
    output logic                mi,
    output logic                ro,
    output logic                ri,
    output logic                ii,
    output logic                io,
    output logic                ai,
    output logic                ao,
    output logic                bi,
    output logic                eo,
    output logic                su,
    output logic                fi,
    output logic                oi,
    output logic                hlt,
    output logic [STEP_W-1:0]   step
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(MAX_STEP);

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    ctrl_t             rom_cw, cw;
    logic              last_step, halt_req;

    control_rom #(.OPCODE_W(OPCODE_W)) u_rom (
        .step      (step_q),
        .opcode    (opcode),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .cw        (rom_cw),
        .last_step (last_step),
        .halt_req  (halt_req)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (run && !halted_q) begin
            // HLT parks on T2 so the frozen step shows where it stopped.
            if (halt_req)
                halted_d = 1'b1;
            else if (last_step || step_q >= LAST)
                step_d = '0;
            else
                step_d = step_q + 3'd1;
        end
    end

    // Reset is sampled synchronously, but the bus must go quiet the moment it asserts.
    assign cw  = (rst && !halted_q) ? rom_cw : '0;
    assign hlt = rst && halted_q;
    assign step = step_q;

    assign co = cw.co;
    assign ce = cw.ce;
    assign j  = cw.j;
    assign mi = cw.mi;
    assign ro = cw.ro;
    assign ri = cw.ri;
    assign ii = cw.ii;
    assign io = cw.io;
    assign ai = cw.ai;
    assign ao = cw.ao;
    assign bi = cw.bi;
    assign eo = cw.eo;
    assign su = cw.su;
    assign fi = cw.fi;
    assign oi = cw.oi;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute words per opcode, jumps,
// halt, single-step hold and a random invariant sweep.
module tb_control_sequencer;

    localparam logic [14:0] CO = 15'h4000, CE = 15'h2000, J  = 15'h1000, MI = 15'h0800;
    localparam logic [14:0] RO = 15'h0400, RI = 15'h0200, II = 15'h0100, IO = 15'h0080;
    localparam logic [14:0] AI = 15'h0040, AO = 15'h0020, BI = 15'h0010, EO = 15'h0008;
    localparam logic [14:0] SU = 15'h0004, FI = 15'h0002, OI = 15'h0001;

    logic       clk = 1'b0;
    logic       rst, run, flag_c, flag_z;
    logic [3:0] opcode;
    logic co, ce, j, mi, ro, ri, ii, io, ai, ao, bi, eo, su, fi, oi, hlt;
    logic [2:0] step;
    logic [14:0] cw;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign cw = {co, ce, j, mi, ro, ri, ii, io, ai, ao, bi, eo, su, fi, oi};

    control_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .co(co), .ce(ce), .j(j), .mi(mi), .ro(ro), .ri(ri), .ii(ii), .io(io),
        .ai(ai), .ao(ao), .bi(bi), .eo(eo), .su(su), .fi(fi), .oi(oi), .hlt(hlt), .step(step)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [3:0] op);
        rst = 1'b0; run = 1'b1; opcode = op; flag_c = 1'b0; flag_z = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] exp [0:4];
        exp = '{CO|MI, RO|II|CE, IO|MI, RO|AI, 15'h0};
        rst = 1'b0; run = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cw !== 15'h0 || hlt !== 1'b0 || step !== 3'd0) begin
                $display("FAIL reset_hold cyc%0d: cw=%h hlt=%b step=%0d want cw=0 hlt=0 step=0", i, cw, hlt, step);
                bad++;
            end
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (step !== 3'(i) || cw !== exp[i]) begin
                $display("FAIL lda_step T%0d: step=%0d cw=%h want step=%0d cw=%h", i, step, cw, i, exp[i]);
                bad++;
            end
            tick();
        end
        total++;
        if (step !== 3'd0 || cw !== (CO|MI)) begin
            $display("FAIL lda_wrap: step=%0d cw=%h want step=0 cw=%h", step, cw, CO|MI);
            bad++;
        end
    endtask

    task automatic test_arith(input logic [3:0] op, input logic [14:0] sub_bit);
        logic [14:0] exp [0:4];
        exp = '{CO|MI, RO|II|CE, IO|MI, RO|BI, EO|AI|FI|sub_bit};
        do_reset(op);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (step !== 3'(i) || cw !== exp[i]) begin
                $display("FAIL arith op%h T%0d: step=%0d cw=%h want step=%0d cw=%h", op, i, step, cw, i, exp[i]);
                bad++;
            end
            tick();
        end
        total++;
        if (step !== 3'd0) begin
            $display("FAIL arith op%h end: step=%0d want 0", op, step);
            bad++;
        end
    endtask

    // One-shot T2 ops: checks the T2 word and that the next step is T0.
    task automatic test_single(input logic [3:0] op, input logic fc, input logic fz, input logic [14:0] exp2);
        do_reset(op);
        flag_c = fc; flag_z = fz;
        tick();
        tick();
        #1;
        total++;
        if (step !== 3'd2 || cw !== exp2) begin
            $display("FAIL t2 op%h c%b z%b: step=%0d cw=%h want step=2 cw=%h", op, fc, fz, step, cw, exp2);
            bad++;
        end
        tick();
        total++;
        if (step !== 3'd0 || cw !== (CO|MI)) begin
            $display("FAIL end op%h c%b z%b: step=%0d cw=%h want step=0 cw=%h", op, fc, fz, step, cw, CO|MI);
            bad++;
        end
    endtask

    task automatic test_sta();
        do_reset(4'h4);
        tick();
        tick();
        tick();
        total++;
        if (step !== 3'd3 || cw !== (AO|RI)) begin
            $display("FAIL sta_t3: step=%0d cw=%h want step=3 cw=%h", step, cw, AO|RI);
            bad++;
        end
        tick();
        total++;
        if (step !== 3'd0) begin
            $display("FAIL sta_end: step=%0d want 0", step);
            bad++;
        end
    endtask

    task automatic test_hlt();
        do_reset(4'hF);
        tick();
        tick();
        total++;
        if (step !== 3'd2 || cw !== 15'h0 || hlt !== 1'b0) begin
            $display("FAIL hlt_t2: step=%0d cw=%h hlt=%b want step=2 cw=0 hlt=0", step, cw, hlt);
            bad++;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            opcode = 4'(i);
            #1;
            total++;
            if (hlt !== 1'b1 || step !== 3'd2 || cw !== 15'h0) begin
                $display("FAIL halted cyc%0d: hlt=%b step=%0d cw=%h want hlt=1 step=2 cw=0", i, hlt, step, cw);
                bad++;
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (hlt !== 1'b0 || cw !== 15'h0) begin
            $display("FAIL hlt_rst_gate: hlt=%b cw=%h want hlt=0 cw=0", hlt, cw);
            bad++;
        end
        tick();
        rst = 1'b1; opcode = 4'h0;
        #1;
        total++;
        if (hlt !== 1'b0 || step !== 3'd0 || cw !== (CO|MI)) begin
            $display("FAIL hlt_clear: hlt=%b step=%0d cw=%h want hlt=0 step=0 cw=%h", hlt, step, cw, CO|MI);
            bad++;
        end
    endtask

    task automatic test_run_hold();
        do_reset(4'h0);
        tick();
        tick();
        tick();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (step !== 3'd3 || cw !== (RO|AI)) begin
                $display("FAIL run_hold cyc%0d: step=%0d cw=%h want step=3 cw=%h", i, step, cw, RO|AI);
                bad++;
            end
            tick();
        end
        run = 1'b1;
        tick();
        total++;
        if (step !== 3'd0) begin
            $display("FAIL run_resume: step=%0d want 0", step);
            bad++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset(4'h1);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (cw !== 15'h0) begin
            $display("FAIL midrst_gate: cw=%h want 0", cw);
            bad++;
        end
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (step !== 3'd0 || cw !== (CO|MI)) begin
            $display("FAIL midrst_resume: step=%0d cw=%h want step=0 cw=%h", step, cw, CO|MI);
            bad++;
        end
    endtask

    task automatic test_random();
        int drivers;
        int errs = 0;
        do_reset(4'h0);
        for (int i = 0; i < 10000; i++) begin
            opcode = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            run    = ($urandom_range(0, 3) != 0);
            rst    = !hlt;
            #1;
            drivers = int'(co) + int'(ro) + int'(io) + int'(ao) + int'(eo);
            total++;
            if (drivers > 1 || (ro && ri) || step > 3'd4) begin
                if (errs < 10)
                    $display("FAIL invariant cyc%0d: drivers=%0d ro=%b ri=%b step=%0d want drivers<=1 !(ro&ri) step<=4",
                             i, drivers, ro, ri, step);
                errs++;
                bad++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_arith(4'h1, 15'h0);
        test_arith(4'h2, SU);
        test_single(4'h7, 1'b0, 1'b1, 15'h0);
        test_single(4'h7, 1'b1, 1'b0, IO|J);
        test_single(4'h8, 1'b1, 1'b0, 15'h0);
        test_single(4'h8, 1'b0, 1'b1, IO|J);
        test_single(4'h6, 1'b0, 1'b0, IO|J);
        test_single(4'h5, 1'b0, 1'b0, IO|AI);
        test_single(4'hE, 1'b0, 1'b0, AO|OI);
        test_single(4'h3, 1'b1, 1'b1, 15'h0);
        test_sta();
        test_hlt();
        test_run_hold();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
